// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes and the memfile port signals that
// mem_port_arbiter sits between.
//
// Parameters: AW address width, DW data width.
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester -> arbiter
//   gnt0/gnt1, rvalid0/rvalid1, rdata0/rdata1,
//   err0/err1                                      : arbiter -> requester
//   mem_write, mem_wr_addr, mem_wr_data,
//   mem_rd_addr                                    : arbiter -> memfile
//   mem_rd_data                                    : memfile -> arbiter
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memfile)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          err0;
    logic          err1;
    logic          mem_write;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_write, mem_wr_addr, mem_wr_data, mem_rd_addr,
        input  mem_rd_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_write, mem_wr_addr, mem_wr_data, mem_rd_addr,
        output mem_rd_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the memfile write port and read port A between two requesters
// (req 0 = CPU datapath, req 1 = debug/loader). At most one requester is
// granted per cycle; the grant is combinational and the transaction completes
// in that cycle. Read data comes back one cycle later on the issuing
// requester's rvalid/rdata. Writes at or above WR_LIMIT are consumed but not
// performed, and flag a one-cycle err pulse on the following cycle.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset; all outputs are 0 while high
//   bus  : mem_port_arbiter_if.slave (requester handshakes + memfile port)
//
// Parameters:
//   AW, DW     : address / data width
//   MAX_BURST  : consecutive grants one requester may keep while the other waits
//   WR_LIMIT   : first protected write address
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN : when defined, req 0 always wins a conflict and the
//                           round-robin state (lg, bc) is held at 0.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    parameter int WR_LIMIT  = 6
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    logic          lg_q, lg_d;
    logic [3:0]    bc_q, bc_d;
    logic [1:0]    rtag_q, rtag_d;
    logic [1:0]    err_q, err_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic          gnt0, gnt1, any_gnt;
    logic          sel_we, wr_blocked;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration. In round-robin mode a bc of 0 means no burst is in
    // progress (idle cycle or reset), so the last-granted side has no claim
    // and a conflict goes to the other side; this is what makes req 0 win
    // first out of reset with lg=1.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0;
            gnt1 = bus.req1 & ~bus.req0;
`else
            if (bus.req0 && bus.req1) begin
                if ((bc_q != 4'd0) && (bc_q < 4'(MAX_BURST))) begin
                    gnt0 = ~lg_q;
                    gnt1 = lg_q;
                end else begin
                    gnt0 = lg_q;
                    gnt1 = ~lg_q;
                end
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
`endif
        end
    end

    // Issue mux and next-state logic.
    always_comb begin
        any_gnt    = gnt0 | gnt1;
        sel_we     = gnt1 ? bus.we1    : bus.we0;
        sel_addr   = gnt1 ? bus.addr1  : bus.addr0;
        sel_wdata  = gnt1 ? bus.wdata1 : bus.wdata0;
        wr_blocked = sel_addr >= AW'(WR_LIMIT);

        lg_d      = lg_q;
        bc_d      = bc_q;
        rd_addr_d = any_gnt ? sel_addr : rd_addr_q;
        rtag_d    = {gnt1 & ~sel_we, gnt0 & ~sel_we};
        err_d     = {gnt1 & sel_we & wr_blocked, gnt0 & sel_we & wr_blocked};

`ifdef MEM_ARB_FIXED_PRIO_EN
        lg_d = 1'b0;
        bc_d = 4'd0;
`else
        if (any_gnt) begin
            // gnt1 equals lg_q exactly when the winner is the last-granted side
            if (gnt1 == lg_q) begin
                bc_d = (bc_q == 4'hF) ? bc_q : bc_q + 4'd1;
            end else begin
                lg_d = gnt1;
                bc_d = 4'd1;
            end
        end else begin
            bc_d = 4'd0;
        end
`endif
    end

    // State registers with synchronous reset; a pending read tag is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            lg_q      <= 1'b1;
            bc_q      <= 4'd0;
            rtag_q    <= 2'b00;
            err_q     <= 2'b00;
            rd_addr_q <= '0;
        end else begin
            lg_q      <= lg_d;
            bc_q      <= bc_d;
            rtag_q    <= rtag_d;
            err_q     <= err_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Outputs. Registered responses are gated with rst so nothing leaks out
    // during the reset cycle itself.
    always_comb begin
        bus.gnt0        = gnt0;
        bus.gnt1        = gnt1;
        bus.mem_write   = any_gnt & sel_we & ~wr_blocked;
        bus.mem_wr_addr = any_gnt ? sel_addr : '0;
        bus.mem_wr_data = (any_gnt & sel_we & ~wr_blocked) ? sel_wdata : '0;
        bus.mem_rd_addr = rst ? '0 : rd_addr_d;
        bus.rvalid0     = rtag_q[0] & ~rst;
        bus.rvalid1     = rtag_q[1] & ~rst;
        bus.rdata0      = (rtag_q[0] & ~rst) ? bus.mem_rd_data : '0;
        bus.rdata1      = (rtag_q[1] & ~rst) ? bus.mem_rd_data : '0;
        bus.err0        = err_q[0] & ~rst;
        bus.err1        = err_q[1] & ~rst;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural memfile (registered
// read, synchronous write) and a read-response scoreboard. Honours
// MEM_ARB_FIXED_PRIO_EN for the conflict grant pattern.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW       = 12;
    localparam int DW       = 16;
    localparam int WR_LIMIT = 6;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mem_init = 1'b1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(4), .WR_LIMIT(WR_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural memfile: registered read of rd_addr_A, synchronous write.
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_data_r = '0;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 3) return 16'hBEEF;
        return DW'(a * 7) ^ 16'h5A00;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
        rd_data_r <= mem[bus.mem_rd_addr];
    end

    assign bus.mem_rd_data = rd_data_r;

    // Bench-side model state
    logic [DW-1:0] exp_mem [0:4095];
    rsp_t          sb[$];
    logic [1:0]    err_pend     = 2'b00;
    logic [AW-1:0] last_rd_addr = '0;
    logic          cur_we0, cur_we1;
    logic [AW-1:0] cur_a0, cur_a1;
    logic [DW-1:0] cur_d0, cur_d1;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                  input logic [DW-1:0] d0, input logic r1, input logic w1,
                                  input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        cur_we0 = w0; cur_a0 = a0; cur_d0 = d0;
        cur_we1 = w1; cur_a1 = a1; cur_d1 = d1;
        #1;
    endtask

    task automatic check_output(input logic eg0, input logic eg1, input string tag);
        rsp_t          e;
        logic          gw, exp_mw;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " rvalid0"}, bus.rvalid0, !e.port);
            check({tag, " rvalid1"}, bus.rvalid1, e.port);
            check({tag, " rdata"}, e.port ? bus.rdata1 : bus.rdata0, e.data);
            check({tag, " idle rdata"}, e.port ? bus.rdata0 : bus.rdata1, 0);
        end else begin
            check({tag, " rvalid0 idle"}, bus.rvalid0, 0);
            check({tag, " rvalid1 idle"}, bus.rvalid1, 0);
        end
        check({tag, " err0"}, bus.err0, err_pend[0]);
        check({tag, " err1"}, bus.err1, err_pend[1]);
        check({tag, " gnt0"}, bus.gnt0, eg0);
        check({tag, " gnt1"}, bus.gnt1, eg1);
        gw = eg1 ? cur_we1 : cur_we0;
        ga = eg1 ? cur_a1  : cur_a0;
        gd = eg1 ? cur_d1  : cur_d0;
        exp_mw = (eg0 | eg1) && gw && (int'(ga) < WR_LIMIT);
        check({tag, " mem_write"}, bus.mem_write, exp_mw);
        if (eg0 | eg1) last_rd_addr = ga;
        check({tag, " mem_rd_addr"}, bus.mem_rd_addr, last_rd_addr);
        if (exp_mw) begin
            check({tag, " mem_wr_data"}, bus.mem_wr_data, gd);
            exp_mem[ga] = gd;
        end
        if ((eg0 | eg1) && !gw) sb.push_back('{port: eg1, data: exp_mem[ga]});
        err_pend[0] = eg0 && gw && (int'(ga) >= WR_LIMIT);
        err_pend[1] = eg1 && gw && (int'(ga) >= WR_LIMIT);
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst gnt0", bus.gnt0, 0);
            check("rst gnt1", bus.gnt1, 0);
            check("rst mem_write", bus.mem_write, 0);
            check("rst rvalid0", bus.rvalid0, 0);
            check("rst rvalid1", bus.rvalid1, 0);
            check("rst err", {bus.err1, bus.err0}, 0);
            check("rst mem_rd_addr", bus.mem_rd_addr, 0);
            @(posedge clk);
        end
        #1;
        rst          = 1'b0;
        sb.delete();
        err_pend     = 2'b00;
        last_rd_addr = '0;
    endtask

    logic [9:0] rr_pat;

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = init_val(i);
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        cur_we0 = 0; cur_a0 = '0; cur_d0 = '0;
        cur_we1 = 0; cur_a1 = '0; cur_d1 = '0;
        @(posedge clk);
        #1 mem_init = 1'b0;
        do_reset(2);

        // Read of the preloaded word from req 0
        apply_stimulus(1, 0, 12'd3, 0, 0, 0, 0, 0);
        check_output(1, 0, "t1 read");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t1 resp");

        // Write then read back
        apply_stimulus(1, 1, 12'd2, 16'h1234, 0, 0, 0, 0);
        check_output(1, 0, "t2 write");
        apply_stimulus(1, 0, 12'd2, 0, 0, 0, 0, 0);
        check_output(1, 0, "t2 read");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t2 resp");

        // Protected write from req 1: consumed, not performed, one err pulse
        apply_stimulus(0, 0, 0, 0, 1, 1, 12'd40, 16'hDEAD);
        check_output(0, 1, "t3 blocked");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t3 err pulse");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t3 err clear");
        check("t3 mem40 kept", mem[40], init_val(40));
        apply_stimulus(0, 0, 0, 0, 1, 0, 12'd40, 0);
        check_output(0, 1, "t3 read40");

        // Limit boundary: last allowed and first protected address
        apply_stimulus(1, 1, 12'd5, 16'h0F0F, 0, 0, 0, 0);
        check_output(1, 0, "lim addr5");
        apply_stimulus(1, 1, 12'd6, 16'hF0F0, 0, 0, 0, 0);
        check_output(1, 0, "lim addr6");
        apply_stimulus(1, 0, 12'd5, 0, 0, 0, 0, 0);
        check_output(1, 0, "lim read5");
        apply_stimulus(1, 0, 12'd6, 0, 0, 0, 0, 0);
        check_output(1, 0, "lim read6");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "lim idle");

        // Alternating back-to-back reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                apply_stimulus(1, 0, AW'(10 + i), 0, 0, 0, 0, 0);
                check_output(1, 0, "t5 alt0");
            end else begin
                apply_stimulus(0, 0, 0, 0, 1, 0, AW'(20 + i), 0);
                check_output(0, 1, "t5 alt1");
            end
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t5 drain");

        // Sustained conflict from reset
        do_reset(1);
`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_pat = 10'b00_0000_0000;
`else
        rr_pat = 10'b00_1111_0000;
`endif
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, 12'd7, 0, 1, 0, 12'd9, 0);
            check_output(!rr_pat[i], rr_pat[i], "t4 conflict");
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t4 drain");

        // Reset with a read in flight
        apply_stimulus(1, 0, 12'd3, 0, 0, 0, 0, 0);
        check_output(1, 0, "t6 read");
        do_reset(2);
        apply_stimulus(1, 0, 12'd3, 0, 1, 0, 12'd4, 0);
        check_output(1, 0, "t6 first gnt");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t6 resp");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output(0, 0, "t6 quiet");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
